bin2sc_sng: RTL and testbench
=============================

Name: bin2sc_sng

Overview:
- Stochastic number generator: converts one BITWIDTH-bit binary word into a serial stochastic bitstream of exactly 2^BITWIDTH bits.
- The fraction of 1s in that stream encodes the word.
- Sits at the input of the SC datapath, upstream of the SC-to-binary / ReLU stage, and performs the reverse conversion of that stage.
- Ready/valid on both sides; supports back-to-back words without bubbles.

Parameters:
- BITWIDTH, 8, word width N; stream length is 2^N. Legal range 4..16.
- BIPOLAR, 1, 1: input is two's complement, threshold = {~bin[N-1], bin[N-2:0]}; 0: input is unsigned, threshold = bin.
- RNG_MODE, 0, 0: random source is the bit-reversed stream counter; 1: maximal-length Fibonacci LFSR.
- SEED, 1, LFSR seed loaded at each word start (RNG_MODE=1 only). Must be non-zero, otherwise compile-time error.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- bin_in, input, BITWIDTH, binary word.
- in_valid, input, 1, bin_in valid.
- in_ready, output, 1, block can accept a word.
- sc_out, output, 1, stochastic bit.
- sc_valid, output, 1, sc_out valid.
- sc_ready, input, 1, downstream accepts sc_out.
- sc_last, output, 1, high with the final (2^N-th) bit of a stream.
- busy, output, 1, a stream is in progress.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset values: sc_valid=0, sc_out=0, sc_last=0, busy=0, in_ready=1. Internal state: IDLE, cnt=0, thr=0, LFSR=SEED.
- States:
  - IDLE: no stream in progress.
  - RUN: stream in progress. busy = (state==RUN).
- Load event: in_valid & in_ready.
- Accept event: sc_valid & sc_ready.
- in_ready = IDLE | (RUN & accept & sc_last). This gives a zero-bubble handover; in_ready is combinational from state and sc_ready.
- On load:
  - Latch thr from bin_in per BIPOLAR.
  - cnt <= 0; LFSR <= SEED.
  - Register the first bit. sc_valid=1 on the cycle after load (latency 1).
  - Go to RUN.
- Random value r for stream index cnt:
  - RNG_MODE=0: r = bit-reverse(cnt).
  - RNG_MODE=1: r = LFSR state for cnt < 2^N-1, and r = 0 for cnt = 2^N-1 (forced zero).
  - In both modes, r spans 0..2^N-1 exactly once per stream.
- Output bit: sc_out = (r < thr), unsigned compare.
  - The count of 1s per stream equals thr exactly.
  - thr is N bits, so a maximum of 2^N-1 ones.
- Backpressure: while sc_valid & ~sc_ready, hold sc_out, sc_last, cnt and LFSR stable.
- On accept with cnt < 2^N-1:
  - cnt++.
  - Advance the LFSR (mode 1).
  - Register the next bit.
- sc_last = sc_valid & (cnt == 2^N-1).
- On accept of the last bit:
  - If a load also occurs in the same cycle, restart per the load rules and stay in RUN.
  - Otherwise go to IDLE with sc_valid=0.
- in_valid while busy and not on the last-accept cycle is ignored; in_ready stays 0.
- bin_in is only sampled on load. Later changes to bin_in do not affect the current stream.
- reset_n asserted mid-stream: immediate return to reset values; the partial stream is discarded.
- LFSR taps come from the package table, indexed by BITWIDTH. Example: N=8 uses x^8+x^6+x^5+x^4+1.

Decomposition:
- Package sc_pkg holds:
  - LFSR tap constant function, indexed by width 4..16.
  - bit-reverse function.
  - state enum {IDLE, RUN}.
- One sub-module, sc_rng. Inputs: clk, reset_n, load, advance, cnt. Output: r. It encapsulates the RNG_MODE selection, the LFSR and the forced-zero rule.
- The top-level module keeps the FSM, counter, threshold register and output registers.

Test Plan:
- Unsigned count (BITWIDTH=8, BIPOLAR=0, RNG_MODE=0), bin_in=0x40, sc_ready=1:
  - sc_valid rises 1 cycle after load.
  - 256 bits with exactly 64 ones.
  - First bit =1 (r=0).
  - sc_last on bit 256 only, then busy=0.
- Bipolar extremes:
  - bin_in=0x80 -> 256 zeros.
  - bin_in=0x7F -> 255 ones; final bit 0 (r=255).
  - bin_in=0x00 -> 128 ones.
- Backpressure: sc_ready toggled randomly and held low 10 cycles mid-stream -> sc_out/sc_last stable while stalled; total 1s still equals thr; stream still has 256 accepted bits.
- Back-to-back: in_valid held high with 0x10 then 0xF0 -> second load coincides with the last accept of the first stream; no idle cycle between streams; counts 16 and 240.
- LFSR mode (RNG_MODE=1, SEED=1), bin_in=0xA5 unsigned -> exactly 165 ones; bit 256 equals (0 < 165)=1; the set of r values over the stream covers 0..255 once.
- Reset mid-stream: assert reset_n low at bit 100 -> outputs go to reset values in the same cycle (async). A new load afterward produces a full correct 256-bit stream.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing front end:
// FSM state enum, LFSR tap table and counter bit reversal.
package sc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Fibonacci tap masks for maximal-length sequences: bit (k-1) set for tap x^k.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        logic [15:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    // Reverses the low 'width' bits of v; the upper bits of the result are zero.
    function automatic logic [15:0] bit_rev(input logic [15:0] v, input int unsigned width);
        logic [15:0] full;
        full = {<<{v}};
        return full >> (16 - width);
    endfunction

endpackage

// File: rtl/sc_rng.sv
// Random source for the SNG: bit-reversed counter or Fibonacci LFSR with the
// final index forced to zero so every value 0..2^N-1 appears once per stream.
module sc_rng
    import sc_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned RNG_MODE = 0,
    parameter int unsigned SEED     = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic                advance,
    input  logic [BITWIDTH-1:0] cnt,
    output logic [BITWIDTH-1:0] r
);

    localparam logic [BITWIDTH-1:0] TAPS   = BITWIDTH'(lfsr_taps(BITWIDTH));
    localparam logic [BITWIDTH-1:0] SEED_W = BITWIDTH'(SEED);

    logic [BITWIDTH-1:0] r_lfsr;
    logic [BITWIDTH-1:0] w_lfsr_nxt;
    logic                w_fb;

    // r looks through this cycle's load/advance so the caller can register
    // the bit that matches the index it is moving to.
    always_comb begin
        w_fb = ^(r_lfsr & TAPS);
        if (load)
            w_lfsr_nxt = SEED_W;
        else if (advance)
            w_lfsr_nxt = {r_lfsr[BITWIDTH-2:0], w_fb};
        else
            w_lfsr_nxt = r_lfsr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_lfsr <= SEED_W;
        else
            r_lfsr <= w_lfsr_nxt;
    end

    if (RNG_MODE == 0) begin : g_counter
        assign r = BITWIDTH'(bit_rev(16'(cnt), BITWIDTH));
    end else begin : g_lfsr
        assign r = (&cnt) ? '0 : w_lfsr_nxt;
    end

endmodule

// File: rtl/bin2sc_sng.sv
// Binary-to-stochastic converter: one N-bit word in, 2^N serial bits out whose
// count of ones equals the threshold derived from the word.
//   state | meaning
//   IDLE  | no stream in progress, ready for a word
//   RUN   | stream in progress, sc_out valid every cycle
module bin2sc_sng
    import sc_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned BIPOLAR  = 1,
    parameter int unsigned RNG_MODE = 0,
    parameter int unsigned SEED     = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BITWIDTH-1:0] bin_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                sc_out,
    output logic                sc_valid,
    input  logic                sc_ready,
    output logic                sc_last,
    output logic                busy
);

    if (BITWIDTH < 4 || BITWIDTH > 16) begin : g_bad_width
        $error("bin2sc_sng: BITWIDTH must be within 4..16");
    end
    if (RNG_MODE == 1 && (SEED & ((1 << BITWIDTH) - 1)) == 0) begin : g_bad_seed
        $error("bin2sc_sng: SEED must be non-zero in LFSR mode");
    end

    localparam logic [BITWIDTH-1:0] CNT_MAX = '1;

    state_t              r_state, w_state_nxt;
    logic [BITWIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [BITWIDTH-1:0] r_thr, w_thr_nxt, w_thr_in;
    logic [BITWIDTH-1:0] w_r;
    logic                r_sc_out;
    logic                w_load, w_accept, w_last, w_advance;

    assign busy     = (r_state == RUN);
    assign sc_valid = (r_state == RUN);
    assign sc_out   = r_sc_out;
    assign w_accept = sc_valid & sc_ready;
    assign w_last   = sc_valid & (r_cnt == CNT_MAX);
    assign sc_last  = w_last;
    // Ready on the last accept lets the next word start with no bubble.
    assign in_ready  = (r_state == IDLE) | (w_accept & w_last);
    assign w_load    = in_valid & in_ready;
    assign w_advance = w_accept & ~w_last;

    // Bipolar: flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1.
    assign w_thr_in = (BIPOLAR != 0) ? {~bin_in[BITWIDTH-1], bin_in[BITWIDTH-2:0]} : bin_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_thr_nxt   = r_thr;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                    w_thr_nxt   = w_thr_in;
                end
            end
            RUN: begin
                if (w_load) begin
                    w_cnt_nxt = '0;
                    w_thr_nxt = w_thr_in;
                end else if (w_accept & w_last) begin
                    w_state_nxt = IDLE;
                end else if (w_advance) begin
                    w_cnt_nxt = r_cnt + BITWIDTH'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_thr    <= '0;
            r_sc_out <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_thr   <= w_thr_nxt;
            if (w_load || w_advance)
                r_sc_out <= (w_r < w_thr_nxt);
            else if (w_state_nxt == IDLE)
                r_sc_out <= 1'b0;
        end
    end

    sc_rng #(
        .BITWIDTH(BITWIDTH),
        .RNG_MODE(RNG_MODE),
        .SEED    (SEED)
    ) u_rng (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (w_load),
        .advance(w_advance),
        .cnt    (w_cnt_nxt),
        .r      (w_r)
    );

endmodule

// File: tb/tb_bin2sc_sng.sv
// Scoreboard bench for bin2sc_sng: unsigned/counter, bipolar/counter and
// unsigned/LFSR instances share stimulus; a negedge monitor checks each stream.
module tb_bin2sc_sng;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] bin_in;
    logic       in_valid;
    logic       sc_ready;
    logic       in_ready[3];
    logic       sc_out[3];
    logic       sc_valid[3];
    logic       sc_last[3];
    logic       busy[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bin2sc_sng #(
            .BITWIDTH(8),
            .BIPOLAR ((g == 1) ? 1 : 0),
            .RNG_MODE((g == 2) ? 1 : 0),
            .SEED    (1)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bin_in  (bin_in),
            .in_valid(in_valid),
            .in_ready(in_ready[g]),
            .sc_out  (sc_out[g]),
            .sc_valid(sc_valid[g]),
            .sc_ready(sc_ready),
            .sc_last (sc_last[g]),
            .busy    (busy[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;
    int exp_bits[3][$];   // per accepted bit: 0/1, or 2 when only the count is known
    int exp_ones[3][$];
    int ones[3];
    int nbits[3];
    bit stalled[3];
    logic prev_out[3];
    logic prev_last[3];
    int rand_rdy   = 0;
    int stall_left = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t: got %0d expected %0d", name, inst, $time, act, exp);
        end
    endtask

    function automatic int rev8(input int k);
        int r = 0;
        for (int b = 0; b < 8; b++)
            if ((k >> b) & 1) r += 1 << (7 - b);
        return r;
    endfunction

    // Number of ones the stream must carry: unsigned value, or signed value + 128.
    function automatic int model_thr(input int inst, input int w);
        int v;
        if (inst == 1) begin
            v = (w >= 128) ? w - 256 : w;
            return v + 128;
        end
        return w;
    endfunction

    always @(negedge clk) begin : mon
        int q;
        int e;
        int t;
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                exp_bits[i].delete();
                exp_ones[i].delete();
                ones[i]    = 0;
                nbits[i]   = 0;
                stalled[i] = 0;
            end
            q = exp_bits[i].size();
            check("busy", i, busy[i], q > 0);
            check("sc_valid", i, sc_valid[i], q > 0);
            check("in_ready", i, in_ready[i], (q == 0) || (q == 1 && sc_ready));
            if (q > 0) begin
                check("sc_last", i, sc_last[i], q == 1);
                if (stalled[i]) begin
                    check("hold_out", i, sc_out[i], prev_out[i]);
                    check("hold_last", i, sc_last[i], prev_last[i]);
                end
                stalled[i]   = !sc_ready;
                prev_out[i]  = sc_out[i];
                prev_last[i] = sc_last[i];
                if (sc_ready) begin
                    e = exp_bits[i].pop_front();
                    if (e != 2) check("bit", i, sc_out[i], e);
                    ones[i]  += (sc_out[i] === 1'b1) ? 1 : 0;
                    nbits[i] += 1;
                    if (exp_bits[i].size() == 0) begin
                        check("ones", i, ones[i], exp_ones[i].pop_front());
                        ones[i]  = 0;
                        nbits[i] = 0;
                    end
                end
            end else begin
                stalled[i] = 0;
            end
            if (reset_n && in_valid && in_ready[i]) begin
                t = model_thr(i, int'(bin_in));
                exp_ones[i].push_back(t);
                for (int k = 0; k < 256; k++) begin
                    if (i == 2)
                        exp_bits[i].push_back((k == 255) ? ((t > 0) ? 1 : 0) : 2);
                    else
                        exp_bits[i].push_back((rev8(k) < t) ? 1 : 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            sc_ready = 1'b0;
            stall_left--;
        end else if (rand_rdy != 0) begin
            sc_ready = 1'($urandom_range(0, 1));
        end else begin
            sc_ready = 1'b1;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input bit keep);
        int guard = 0;
        in_valid = 1'b1;
        bin_in   = w;
        while (!in_ready[0] && guard < 3000) begin
            tick();
            guard++;
        end
        check("load_wait_expired", 0, guard >= 3000, 0);
        tick();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy[0] || exp_bits[0].size() > 0) && guard < 3000) begin
            tick();
            guard++;
        end
        check("idle_wait_expired", 0, guard >= 3000, 0);
    endtask

    task automatic wait_bits(input int n);
        int guard = 0;
        while (nbits[0] < n && guard < 3000) begin
            tick();
            guard++;
        end
        check("bit_wait_expired", 0, guard >= 3000, 0);
    endtask

    task automatic check_reset_vals();
        for (int i = 0; i < 3; i++) begin
            check("rst_sc_valid", i, sc_valid[i], 0);
            check("rst_sc_out", i, sc_out[i], 0);
            check("rst_sc_last", i, sc_last[i], 0);
            check("rst_busy", i, busy[i], 0);
            check("rst_in_ready", i, in_ready[i], 1);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        bin_in   = 8'h00;
        sc_ready = 1'b1;
        repeat (3) tick();
        check_reset_vals();
        reset_n = 1'b1;
        tick();

        // Unsigned 0x40: first bit one cycle after load, 64 ones.
        send_word(8'h40, 1'b0);
        check("latency", 0, sc_valid[0], 1);
        check("first_bit", 0, sc_out[0], 1);
        wait_idle();
        tick();
        check("busy_after", 0, busy[0], 0);

        // Bipolar extremes and the LFSR word.
        send_word(8'h80, 1'b0);
        wait_idle();
        send_word(8'h7F, 1'b0);
        wait_idle();
        send_word(8'h00, 1'b0);
        wait_idle();
        send_word(8'hA5, 1'b0);
        wait_idle();

        // Random backpressure plus a 10-cycle stall mid-stream.
        rand_rdy = 1;
        send_word(8'($urandom_range(0, 255)), 1'b0);
        wait_bits(100);
        stall_left = 10;
        wait_idle();
        rand_rdy = 0;

        // Back-to-back words with in_valid held high.
        send_word(8'h10, 1'b1);
        send_word(8'hF0, 1'b0);
        wait_idle();

        // Random words with random gaps and random ready.
        rand_rdy = 1;
        for (int n = 0; n < 6; n++) begin
            send_word(8'($urandom_range(0, 255)), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_idle();
        rand_rdy = 0;

        // Asynchronous reset mid-stream, then a fresh full stream.
        send_word(8'h5A, 1'b0);
        wait_bits(100);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        send_word(8'hC3, 1'b0);
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
